pu_msp430_dac_spi_ctrl: RTL and testbench

PU_MSP430_DAC_SPI_CTRL -- requirements
Module: pu_msp430_dac_spi_ctrl

---
 rtl/pu_msp430_dac_spi_ctrl.sv | 164 ++++++++++++++++
 tb/tb_pu_msp430_dac_spi_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pu_msp430_dac_spi_ctrl.sv
// Two-requester SPI master for a 16-bit serial DAC frame {hdr, data}.
// Round-robin grant, registered SPI pins, trailing falling edge commits the word.
module pu_msp430_dac_spi_ctrl #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic        mclk_i,
    input  logic        puc_rst_i,
    input  logic        req0_i,
    input  logic [11:0] data0_i,
    output logic        ack0_o,
    input  logic        req1_i,
    input  logic [11:0] data1_i,
    output logic        ack1_o,
    input  logic [3:0]  hdr_i,
    output logic        busy_o,
    output logic        grant_id_o,
    output logic        sync_n_o,
    output logic        scl_o,
    output logic        din_o
);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, TRAIL} state_e;

    localparam logic [7:0] HLAST = 8'(CLK_DIV - 1);

    state_e      state_q, state_d;
    logic [7:0]  hcnt_q, hcnt_d;
    logic [3:0]  bcnt_q, bcnt_d;
    logic [15:0] frame_q, frame_d;
    logic        scl_q, scl_d;
    logic        din_q, din_d;
    logic        sync_n_q, sync_n_d;
    logic        busy_q, busy_d;
    logic        gid_q, gid_d;
    logic        rr_q, rr_d;
    logic        ack0_q, ack0_d;
    logic        ack1_q, ack1_d;
    logic        hdone;
    logic        gsel;

    assign hdone = (hcnt_q == HLAST);

    always_comb begin
        state_d  = state_q;
        hcnt_d   = hcnt_q;
        bcnt_d   = bcnt_q;
        frame_d  = frame_q;
        scl_d    = scl_q;
        din_d    = din_q;
        sync_n_d = sync_n_q;
        busy_d   = busy_q;
        gid_d    = gid_q;
        rr_d     = rr_q;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        gsel     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req0_i || req1_i) begin
                    // rr_q names the requester that wins a tie
                    gsel     = (req0_i && req1_i) ? rr_q : req1_i;
                    frame_d  = {hdr_i, gsel ? data1_i : data0_i};
                    din_d    = hdr_i[3];
                    sync_n_d = 1'b0;
                    scl_d    = 1'b1;
                    busy_d   = 1'b1;
                    gid_d    = gsel;
                    rr_d     = ~gsel;
                    ack0_d   = ~gsel;
                    ack1_d   = gsel;
                    hcnt_d   = 8'd0;
                    bcnt_d   = 4'd15;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                if (hdone) begin
                    hcnt_d  = 8'd0;
                    scl_d   = 1'b0;
                    state_d = SHIFT;
                end else begin
                    hcnt_d = hcnt_q + 8'd1;
                end
            end
            SHIFT: begin
                if (!hdone) begin
                    hcnt_d = hcnt_q + 8'd1;
                end else begin
                    hcnt_d = 8'd0;
                    if (!scl_q) begin
                        // Rising edge: present the next bit so it is settled
                        // well before the following falling edge.
                        scl_d = 1'b1;
                        if (bcnt_q != 4'd0) begin
                            frame_d = {frame_q[14:0], 1'b0};
                            din_d   = frame_q[14];
                        end
                    end else if (bcnt_q == 4'd0) begin
                        sync_n_d = 1'b1;
                        din_d    = 1'b0;
                        state_d  = TRAIL;
                    end else begin
                        bcnt_d = bcnt_q - 4'd1;
                        scl_d  = 1'b0;
                    end
                end
            end
            TRAIL: begin
                if (!hdone) begin
                    hcnt_d = hcnt_q + 8'd1;
                end else begin
                    hcnt_d = 8'd0;
                    if (scl_q) begin
                        scl_d = 1'b0;
                    end else begin
                        scl_d   = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge mclk_i) begin
        if (puc_rst_i) begin
            state_q  <= IDLE;
            hcnt_q   <= 8'd0;
            bcnt_q   <= 4'd0;
            frame_q  <= 16'd0;
            scl_q    <= 1'b1;
            din_q    <= 1'b0;
            sync_n_q <= 1'b1;
            busy_q   <= 1'b0;
            gid_q    <= 1'b0;
            rr_q     <= 1'b0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            hcnt_q   <= hcnt_d;
            bcnt_q   <= bcnt_d;
            frame_q  <= frame_d;
            scl_q    <= scl_d;
            din_q    <= din_d;
            sync_n_q <= sync_n_d;
            busy_q   <= busy_d;
            gid_q    <= gid_d;
            rr_q     <= rr_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
        end
    end

    assign ack0_o     = ack0_q;
    assign ack1_o     = ack1_q;
    assign busy_o     = busy_q;
    assign grant_id_o = gid_q;
    assign sync_n_o   = sync_n_q;
    assign scl_o      = scl_q;
    assign din_o      = din_q;

endmodule

// File: tb/tb_pu_msp430_dac_spi_ctrl.sv
// Bench for pu_msp430_dac_spi_ctrl: DAC shift-register model feeds a scoreboard,
// one instance at CLK_DIV=2 and one at CLK_DIV=1.
module tb_pu_msp430_dac_spi_ctrl;

    logic mclk = 1'b0;
    always #5 mclk = ~mclk;

    logic        rst_a, req0_a, req1_a, ack0_a, ack1_a, busy_a, gid_a, syn_a, scl_a, din_a;
    logic [11:0] d0_a, d1_a;
    logic [3:0]  hdr_a;
    logic        rst_b, req0_b, req1_b, ack0_b, ack1_b, busy_b, gid_b, syn_b, scl_b, din_b;
    logic [11:0] d0_b, d1_b;
    logic [3:0]  hdr_b;

    pu_msp430_dac_spi_ctrl #(.CLK_DIV(2)) u_dut_a (
        .mclk_i(mclk), .puc_rst_i(rst_a),
        .req0_i(req0_a), .data0_i(d0_a), .ack0_o(ack0_a),
        .req1_i(req1_a), .data1_i(d1_a), .ack1_o(ack1_a),
        .hdr_i(hdr_a), .busy_o(busy_a), .grant_id_o(gid_a),
        .sync_n_o(syn_a), .scl_o(scl_a), .din_o(din_a)
    );

    pu_msp430_dac_spi_ctrl #(.CLK_DIV(1)) u_dut_b (
        .mclk_i(mclk), .puc_rst_i(rst_b),
        .req0_i(req0_b), .data0_i(d0_b), .ack0_o(ack0_b),
        .req1_i(req1_b), .data1_i(d1_b), .ack1_o(ack1_b),
        .hdr_i(hdr_b), .busy_o(busy_b), .grant_id_o(gid_b),
        .sync_n_o(syn_b), .scl_o(scl_b), .din_o(din_b)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    endtask

    // DAC models: shift on falling scl while sync_n low, commit on the
    // falling edge seen with sync_n high after exactly 16 bits.
    logic [15:0] sbq_a[$];
    logic [15:0] sbq_b[$];
    logic [15:0] sr_a = '0, sr_b = '0;
    logic [11:0] vout_a = '0, vout_b = '0;
    int cnt_a = 0, cnt_b = 0, commits_a = 0, commits_b = 0;

    always @(negedge syn_a) cnt_a = 0;
    always @(negedge scl_a) begin
        if (!syn_a) begin
            sr_a = {sr_a[14:0], din_a};
            cnt_a++;
        end else begin
            if (cnt_a == 16) begin
                vout_a = sr_a[11:0];
                commits_a++;
                if (sbq_a.size() == 0) chk("sb_a_extra_frame", {16'h0, sr_a}, 32'hFFFF_FFFF);
                else chk("sb_a_word", {16'h0, sr_a}, {16'h0, sbq_a.pop_front()});
            end
            cnt_a = 0;
        end
    end

    always @(negedge syn_b) cnt_b = 0;
    always @(negedge scl_b) begin
        if (!syn_b) begin
            sr_b = {sr_b[14:0], din_b};
            cnt_b++;
        end else begin
            if (cnt_b == 16) begin
                vout_b = sr_b[11:0];
                commits_b++;
                if (sbq_b.size() == 0) chk("sb_b_extra_frame", {16'h0, sr_b}, 32'hFFFF_FFFF);
                else chk("sb_b_word", {16'h0, sr_b}, {16'h0, sbq_b.pop_front()});
            end
            cnt_b = 0;
        end
    end

    // din must hold its value across every falling scl edge
    logic pscl_a = 1'b1, pdin_a = 1'b0, pscl_b = 1'b1, pdin_b = 1'b0;
    int dinerr_a = 0, dinerr_b = 0;
    always @(negedge mclk) begin
        if (pscl_a === 1'b1 && scl_a === 1'b0 && din_a !== pdin_a) dinerr_a++;
        if (pscl_b === 1'b1 && scl_b === 1'b0 && din_b !== pdin_b) dinerr_b++;
        pscl_a = scl_a; pdin_a = din_a;
        pscl_b = scl_b; pdin_b = din_b;
    end

    task automatic await_ack(input bit sel, output int who, output int ncyc);
        who = -1;
        ncyc = 0;
        while (who < 0 && ncyc < 300) begin
            @(negedge mclk);
            ncyc++;
            if (sel ? ack0_b : ack0_a) who = 0;
            else if (sel ? ack1_b : ack1_a) who = 1;
        end
        if (who < 0) chk("ack_timeout", ncyc, 0);
    endtask

    task automatic await_idle(input bit sel);
        int n;
        n = 0;
        while ((sel ? busy_b : busy_a) && n < 300) begin
            @(negedge mclk);
            n++;
        end
        if (n >= 300) chk("idle_timeout", n, 0);
        @(negedge mclk);
    endtask

    typedef struct {
        bit          who;
        logic [11:0] data;
        logic [3:0]  hdr;
        logic [15:0] exp_word;
    } vec_t;

    initial begin
        vec_t tbl[5];
        int who, n, lowc, bfall, nack, cold, errs;
        logic [11:0] vold;
        logic exp_scl;

        tbl[0] = '{1'b0, 12'h000, 4'h0, 16'h0000};
        tbl[1] = '{1'b1, 12'hFFF, 4'hF, 16'hFFFF};
        tbl[2] = '{1'b0, 12'h5A5, 4'h3, 16'h35A5};
        tbl[3] = '{1'b1, 12'h800, 4'h9, 16'h9800};
        tbl[4] = '{1'b0, 12'h001, 4'hC, 16'hC001};

        rst_a = 1; req0_a = 0; req1_a = 0; d0_a = 0; d1_a = 0; hdr_a = 0;
        rst_b = 1; req0_b = 0; req1_b = 0; d0_b = 0; d1_b = 0; hdr_b = 0;
        repeat (3) @(negedge mclk);
        chk("rst_sync_n", syn_a, 1);
        chk("rst_scl", scl_a, 1);
        chk("rst_din", din_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_acks", {ack0_a, ack1_a}, 0);
        chk("rst_gid", gid_a, 0);
        rst_a = 0; rst_b = 0;
        @(negedge mclk);

        // Single frame timing at CLK_DIV=2
        d0_a = 12'hA5C; hdr_a = 4'h0; req0_a = 1;
        sbq_a.push_back(16'h0A5C);
        await_ack(0, who, n);
        req0_a = 0;
        chk("t1_who", who, 0);
        chk("t1_gid", gid_a, 0);
        chk("t1_busy_grant", busy_a, 1);
        lowc = (syn_a == 1'b0) ? 1 : 0;
        bfall = -1;
        for (int c = 1; c <= 80; c++) begin
            @(negedge mclk);
            if (c == 1) chk("t1_ack_width", ack0_a, 0);
            if (!syn_a) lowc++;
            if (!busy_a && bfall < 0) bfall = c;
        end
        chk("t1_sync_low", lowc, 66);
        chk("t1_busy_fall", bfall, 70);
        chk("t1_vout", vout_a, 12'hA5C);

        // Table of single-requester frames; inputs scrambled after ack
        for (int i = 0; i < 5; i++) begin
            hdr_a = tbl[i].hdr;
            if (tbl[i].who) begin d1_a = tbl[i].data; req1_a = 1; end
            else begin d0_a = tbl[i].data; req0_a = 1; end
            sbq_a.push_back(tbl[i].exp_word);
            await_ack(0, who, n);
            req0_a = 0; req1_a = 0;
            chk("tbl_who", who, tbl[i].who);
            chk("tbl_gid", gid_a, tbl[i].who);
            d0_a = ~tbl[i].data; d1_a = ~tbl[i].data; hdr_a = ~tbl[i].hdr;
            await_idle(0);
            chk("tbl_vout", vout_a, tbl[i].exp_word[11:0]);
        end

        // Round-robin with both held after reset: 0, 1, 0 spaced 71 cycles
        rst_a = 1; @(negedge mclk); rst_a = 0;
        d0_a = 12'h111; d1_a = 12'h222; hdr_a = 4'h0;
        sbq_a.push_back(16'h0111); sbq_a.push_back(16'h0222); sbq_a.push_back(16'h0111);
        req0_a = 1; req1_a = 1;
        for (int k = 0; k < 3; k++) begin
            await_ack(0, who, n);
            chk("rr_who", who, k % 2);
            if (k > 0) chk("rr_spacing", n, 71);
        end
        req0_a = 0; req1_a = 0;
        await_idle(0);
        chk("rr_vout", vout_a, 12'h111);

        // Data/hdr change after ack does not disturb the frame
        d0_a = 12'h123; hdr_a = 4'h5; req0_a = 1;
        sbq_a.push_back(16'h5123);
        await_ack(0, who, n);
        req0_a = 0;
        @(negedge mclk);
        d0_a = 12'hFFF; hdr_a = 4'hA;
        await_idle(0);
        chk("late_data_vout", vout_a, 12'h123);

        // One-cycle req1 pulse while busy is ignored
        d0_a = 12'h456; hdr_a = 4'h0; req0_a = 1;
        sbq_a.push_back(16'h0456);
        cold = commits_a;
        await_ack(0, who, n);
        req0_a = 0;
        repeat (10) @(negedge mclk);
        req1_a = 1; @(negedge mclk); req1_a = 0;
        nack = 0;
        for (int c = 0; c < 120; c++) begin
            @(negedge mclk);
            if (ack0_a || ack1_a) nack++;
        end
        chk("pulse_no_ack", nack, 0);
        chk("pulse_one_frame", commits_a - cold, 1);

        // Reset at bit 7 of a 0x800 frame; req0 held through reset
        vold = vout_a; cold = commits_a;
        d1_a = 12'h800; hdr_a = 4'h0; req1_a = 1;
        await_ack(0, who, n);
        req1_a = 0;
        chk("abort_who", who, 1);
        chk("abort_gid", gid_a, 1);
        repeat (35) @(negedge mclk);
        d0_a = 12'h2B7; hdr_a = 4'h3; req0_a = 1;
        sbq_a.push_back(16'h32B7);
        @(negedge mclk);
        chk("abort_no_ack_busy", ack0_a, 0);
        rst_a = 1;
        @(negedge mclk);
        chk("abort_sync_n", syn_a, 1);
        chk("abort_scl", scl_a, 1);
        chk("abort_din", din_a, 0);
        chk("abort_busy", busy_a, 0);
        chk("abort_gid_rst", gid_a, 0);
        chk("abort_acks", {ack0_a, ack1_a}, 0);
        rst_a = 0;
        @(negedge mclk);
        chk("held_req_ack", ack0_a, 1);
        req0_a = 0;
        chk("abort_vout_kept", vout_a, vold);
        chk("abort_no_commit", commits_a, cold);
        await_idle(0);
        chk("after_abort_vout", vout_a, 12'h2B7);

        // CLK_DIV=1: scl pattern over the whole frame
        d1_b = 12'hFFF; hdr_b = 4'h0; req1_b = 1;
        sbq_b.push_back(16'h0FFF);
        await_ack(1, who, n);
        req1_b = 0;
        chk("b_who", who, 1);
        errs = (scl_b !== 1'b1) ? 1 : 0;
        for (int c = 1; c <= 35; c++) begin
            @(negedge mclk);
            if (c <= 32) exp_scl = (c % 2 == 0);
            else exp_scl = (c != 34);
            if (scl_b !== exp_scl) errs++;
        end
        chk("b_scl_pattern", errs, 0);
        chk("b_busy_end", busy_b, 0);
        chk("b_vout_fff", vout_b, 12'hFFF);
        d1_b = 12'h000; req1_b = 1;
        sbq_b.push_back(16'h0000);
        await_ack(1, who, n);
        req1_b = 0;
        await_idle(1);
        chk("b_vout_000", vout_b, 12'h000);

        chk("a_din_stable", dinerr_a, 0);
        chk("b_din_stable", dinerr_b, 0);
        chk("a_sb_empty", sbq_a.size(), 0);
        chk("b_sb_empty", sbq_b.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_chk);
        $fatal(1);
    end

endmodule
